// File: rtl/pc_sequencer_pkg.sv
// pc_sequencer_pkg: shared widths, fetch step and FSM state encoding for the PC sequencer.
package pc_sequencer_pkg;
  localparam int PC_WIDTH = 32;
  localparam logic [PC_WIDTH-1:0] RESET_PC = '0;
  localparam int PC_STEP = 4;
  localparam int OFF_SHIFT = 2;
  typedef enum logic [1:0] {
    S_INIT  = 2'b00,
    S_RUN   = 2'b01,
    S_STALL = 2'b10
  } state_e;
endpackage

// File: rtl/pc_sequencer_branch_target_gen.sv
// branch_target_gen: combinational sequential-PC and branch-target adders.
module branch_target_gen
  import pc_sequencer_pkg::*;
(
  input  logic [PC_WIDTH-1:0] pc_i,
  input  logic [7:0]          offset_i,
  output logic [PC_WIDTH-1:0] seq_o,
  output logic [PC_WIDTH-1:0] target_o
);
  logic [PC_WIDTH-1:0] off_ext;
  assign off_ext  = {{(PC_WIDTH-8){offset_i[7]}}, offset_i} << OFF_SHIFT;
  assign seq_o    = pc_i + PC_WIDTH'(PC_STEP);
  assign target_o = seq_o + off_ext;
endmodule

// File: rtl/pc_sequencer.sv
// pc_sequencer: PC register with branch/jump redirect and stall capture-and-replay.
module pc_sequencer
  import pc_sequencer_pkg::*;
(
  input  logic                clk_i,
  input  logic                reset_i,
  input  logic                dec_valid_i,
  input  logic                jump_i,
  input  logic                branch_eq_i,
  input  logic                branch_ne_i,
  input  logic                zero_i,
  input  logic [7:0]          offset_i,
  input  logic                busywait_i,
  output logic [PC_WIDTH-1:0] pc_o,
  output logic                fetch_en_o,
  output logic                redirect_o,
  output logic                stalled_o
);
  state_e              state_q, state_d;
  logic [PC_WIDTH-1:0] pc_q, pc_d, hold_q, hold_d, seq, target, next_pc;
  logic                hold_taken_q, hold_taken_d, redirect_q, redirect_d, taken;

  branch_target_gen u_btg (
    .pc_i     (pc_q),
    .offset_i (offset_i),
    .seq_o    (seq),
    .target_o (target)
  );

  assign taken   = dec_valid_i & (jump_i | (branch_eq_i & zero_i) | (branch_ne_i & ~zero_i));
  assign next_pc = taken ? target : seq;

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    hold_d       = hold_q;
    hold_taken_d = hold_taken_q;
    redirect_d   = 1'b0;
    case (state_q)
      S_INIT: state_d = S_RUN;
      S_RUN: begin
        if (busywait_i) begin
          hold_d       = next_pc;
          hold_taken_d = taken;
          state_d      = S_STALL;
        end else begin
          pc_d       = next_pc;
          redirect_d = taken;
        end
      end
      // the decision captured on stall entry wins over whatever is on the inputs now
      S_STALL: begin
        if (!busywait_i) begin
          pc_d       = hold_q;
          redirect_d = hold_taken_q;
          state_d    = S_RUN;
        end
      end
      default: state_d = S_INIT;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q      <= S_INIT;
      pc_q         <= RESET_PC;
      hold_q       <= '0;
      hold_taken_q <= 1'b0;
      redirect_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      hold_q       <= hold_d;
      hold_taken_q <= hold_taken_d;
      redirect_q   <= redirect_d;
    end
  end

  assign pc_o       = pc_q;
  assign fetch_en_o = state_q != S_INIT;
  assign stalled_o  = state_q == S_STALL;
  assign redirect_o = redirect_q;
endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer: directed test-plan scenarios plus random stimulus against a behavioural PC model.
module tb_pc_sequencer;
  logic        clk = 0;
  logic        reset, dec_valid, jump, branch_eq, branch_ne, zero, busywait;
  logic [7:0]  offset;
  logic [31:0] pc;
  logic        fetch_en, redirect, stalled;
  int          checks = 0, errors = 0;

  bit          m_init, m_stall, m_red, m_hold_taken;
  logic [31:0] m_pc, m_hold;

  always #5 clk = ~clk;

  pc_sequencer dut (
    .clk_i       (clk),
    .reset_i     (reset),
    .dec_valid_i (dec_valid),
    .jump_i      (jump),
    .branch_eq_i (branch_eq),
    .branch_ne_i (branch_ne),
    .zero_i      (zero),
    .offset_i    (offset),
    .busywait_i  (busywait),
    .pc_o        (pc),
    .fetch_en_o  (fetch_en),
    .redirect_o  (redirect),
    .stalled_o   (stalled)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step(input bit r, input bit dv, input bit j, input bit beq, input bit bne,
                      input bit z, input logic [7:0] off, input bit busy);
    bit tk;
    logic [31:0] nxt;
    @(negedge clk);
    {reset, dec_valid, jump, branch_eq, branch_ne, zero, offset, busywait} = {r, dv, j, beq, bne, z, off, busy};
    @(posedge clk);
    tk  = dv && (j || (beq && z) || (bne && !z));
    nxt = m_pc + 32'd4 + (tk ? 32'($signed(off)) * 32'sd4 : 32'd0);
    if (r) begin
      m_pc = 0; m_init = 1; m_stall = 0; m_red = 0; m_hold = 0; m_hold_taken = 0;
    end else if (m_init) begin
      m_init = 0; m_red = 0;
    end else if (m_stall) begin
      m_red = 0;
      if (!busy) begin m_pc = m_hold; m_red = m_hold_taken; m_stall = 0; end
    end else if (busy) begin
      m_hold = nxt; m_hold_taken = tk; m_stall = 1; m_red = 0;
    end else begin
      m_pc = nxt; m_red = tk;
    end
    #1;
    check("pc", pc, m_pc);
    check("fetch_en", 32'(fetch_en), 32'(!m_init));
    check("redirect", 32'(redirect), 32'(m_red));
    check("stalled", 32'(stalled), 32'(m_stall));
  endtask

  task automatic idle();
    step(0, 1, 0, 0, 0, 1'($urandom), 8'($urandom), 0);
  endtask

  task automatic run_to(input logic [31:0] target);
    int n = 0;
    while (m_pc != target && n < 64) begin idle(); n++; end
    check("run_to", pc, target);
  endtask

  initial begin
    {reset, dec_valid, jump, branch_eq, branch_ne, zero, offset, busywait} = '0;
    step(1, 0, 0, 0, 0, 0, 8'h00, 0);
    check("rst_pc", pc, 32'h0);
    check("rst_fetch", 32'(fetch_en), 32'h0);
    step(0, 1, 1, 0, 0, 0, 8'h10, 0);
    check("init_pc", pc, 32'h0);
    for (int i = 1; i < 4; i++) begin
      idle();
      check("seq_pc", pc, 32'(4 * i));
    end
    run_to(32'h20);
    step(0, 1, 0, 1, 0, 1, 8'hFE, 0);
    check("beq_taken", pc, 32'h1C);
    check("beq_red", 32'(redirect), 32'h1);
    idle();
    check("red_pulse", 32'(redirect), 32'h0);
    step(0, 1, 0, 1, 0, 0, 8'hFE, 0);
    check("beq_not", pc, 32'h24);
    run_to(32'h40);
    step(0, 1, 1, 0, 0, 0, 8'h7F, 1);
    check("stall_pc", pc, 32'h40);
    for (int i = 0; i < 2; i++) begin
      step(0, 1, 1, 1, 1, 1'($urandom), 8'($urandom), 1);
      check("stall_hold", pc, 32'h40);
      check("stall_flag", 32'(stalled), 32'h1);
    end
    step(0, 1, 1, 0, 0, 0, 8'h05, 0);
    check("stall_tgt", pc, 32'h240);
    check("stall_red", 32'(redirect), 32'h1);
    step(0, 0, 0, 0, 1, 0, 8'h33, 0);
    check("dv0_pc", pc, 32'h244);
    check("dv0_red", 32'(redirect), 32'h0);
    step(1, 0, 0, 0, 0, 0, 8'h00, 0);
    idle();
    step(0, 1, 1, 0, 0, 0, 8'h80, 0);
    check("jmp_neg", pc, 32'hFFFFFE04);
    step(0, 1, 1, 0, 0, 0, 8'h7D, 0);
    check("pre_wrap", pc, 32'hFFFFFFFC);
    idle();
    check("wrap", pc, 32'h0);
    step(0, 1, 1, 0, 0, 0, 8'h40, 1);
    step(1, 1, 1, 0, 0, 0, 8'h40, 0);
    check("rst_stall_pc", pc, 32'h0);
    check("rst_stall_red", 32'(redirect), 32'h0);
    check("rst_stall_stl", 32'(stalled), 32'h0);
    idle();
    idle();
    check("hold_dropped", pc, 32'h4);
    for (int i = 0; i < 400; i++)
      step($urandom_range(0, 49) == 0, 1'($urandom), $urandom_range(0, 5) == 0, 1'($urandom),
           1'($urandom), 1'($urandom), 8'($urandom), $urandom_range(0, 2) == 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
